// File: rtl/core_ctrl_pkg.sv
// core_ctrl_pkg: shared state and termination-status encodings for the core run controller
package core_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RESET, RUN, FINISH} run_state_t;
    typedef enum logic [1:0] {ST_NONE, ST_HALT, ST_TIMEOUT, ST_ABORT} run_status_t;
endpackage

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: sequences one program run of the core (reset, run, halt/timeout/abort) with a four-phase req/done handshake
//   clk, reset (async, active-low), req/abort (host levels), prog_ctr (core PC)
//   core_reset/core_en drive the core; busy/done/status/cycle_cnt report to the host
module core_run_ctrl
    import core_ctrl_pkg::*;
#(
    parameter int D          = 12,
    parameter int HALT_ADDR  = 128,
    parameter int RST_CYCLES = 2,
    parameter int CW         = 16,
    parameter int TIMEOUT    = 60000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req,
    input  logic          abort,
    input  logic [D-1:0]  prog_ctr,
    output logic          core_reset,
    output logic          core_en,
    output logic          busy,
    output logic          done,
    output logic [1:0]    status,
    output logic [CW-1:0] cycle_cnt
);
    localparam int RW = $clog2(RST_CYCLES + 1);
    run_state_t    state;
    run_status_t   st_q;
    logic [RW-1:0] rst_cnt;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            st_q      <= ST_NONE;
            cycle_cnt <= '0;
            rst_cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (req) begin
                    state     <= RESET;
                    rst_cnt   <= RW'(RST_CYCLES - 1);
                    cycle_cnt <= '0;
                    st_q      <= ST_NONE;
                end
                RESET: begin
                    rst_cnt <= rst_cnt - 1'b1;
                    if (abort) begin
                        state <= FINISH;
                        st_q  <= ST_ABORT;
                    end else if (rst_cnt == '0)
                        state <= RUN;
                end
                RUN: begin
                    // the terminating edge is counted as a run cycle too
                    cycle_cnt <= cycle_cnt + 1'b1;
                    if (prog_ctr == D'(HALT_ADDR)) begin
                        state <= FINISH;
                        st_q  <= ST_HALT;
                    end else if (abort) begin
                        state <= FINISH;
                        st_q  <= ST_ABORT;
                    end else if (cycle_cnt == CW'(TIMEOUT - 1)) begin
                        state <= FINISH;
                        st_q  <= ST_TIMEOUT;
                    end
                end
                default: if (!req) state <= IDLE;
            endcase
        end
    end
    assign core_reset = state == IDLE || state == RESET;
    assign core_en    = state == RUN;
    assign busy       = state == RESET || state == RUN;
    assign done       = state == FINISH;
    assign status     = st_q;
endmodule
